// File: rtl/data_mem_responder.sv
// Terminating data-memory responder: one request at a time, programmable wait states,
// word-organised SRAM with byte-lane writes and alignment/range/conflict error reporting.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] physical_addr,
  input  logic [31:0] data_in,
  input  logic [3:0]  wstrb,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  wstrb_r;
  logic        rd_r, wr_r;

  logic [31:0]       req_addr_s, req_wdata_s;
  logic [3:0]        req_wstrb_s;
  logic              req_rd_s, req_wr_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic              err_s;
  logic              commit_s;

  logic [31:0] mem [DEPTH_WORDS];

  // Next-state and wait counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_read | mem_write) begin
          if (HAS_WAIT) begin
            state_s = ST_WAIT;
            cnt_s   = CNT_INIT;
          end else begin
            state_s = ST_RESP;
            cnt_s   = 4'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so live inputs are used there
  always_comb begin
    if (state_r == ST_IDLE) begin
      req_addr_s  = physical_addr;
      req_wdata_s = data_in;
      req_wstrb_s = wstrb;
      req_rd_s    = mem_read;
      req_wr_s    = mem_write;
    end else begin
      req_addr_s  = addr_r;
      req_wdata_s = wdata_r;
      req_wstrb_s = wstrb_r;
      req_rd_s    = rd_r;
      req_wr_s    = wr_r;
    end
  end

  assign word_idx_s = req_addr_s[ADDR_W+1:2];
  assign err_s      = (|req_addr_s[1:0]) | (|req_addr_s[31:ADDR_W+2]) | (req_rd_s & req_wr_s);
  assign commit_s   = (state_s == ST_RESP);

  // State, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      data_out  <= 32'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      busy      <= (state_s != ST_IDLE);
      mem_ready <= commit_s;
      if ((state_r == ST_IDLE) && (mem_read | mem_write)) begin
        addr_r  <= physical_addr;
        wdata_r <= data_in;
        wstrb_r <= wstrb;
        rd_r    <= mem_read;
        wr_r    <= mem_write;
      end
      if (commit_s) begin
        mem_err  <= err_s;
        data_out <= (err_s || req_wr_s) ? 32'd0 : mem[word_idx_s];
      end
    end
  end

  // Array is never reset; a reset at the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (reset && commit_s && req_wr_s && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb_s[i]) begin
          mem[word_idx_s][8*i +: 8] <= req_wdata_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder (WAIT_CYCLES=2 and 0 instances)
// against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_addr, a_din, a_dout;
  logic [3:0]  a_strb;
  logic        a_rd, a_wr, a_ready, a_err, a_busy;
  logic [31:0] b_addr, b_din, b_dout;
  logic [3:0]  b_strb;
  logic        b_rd, b_wr, b_ready, b_err, b_busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_dout;
  logic        last_err;
  logic [31:0] b_words [3];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .physical_addr(a_addr), .data_in(a_din), .wstrb(a_strb),
    .mem_read(a_rd), .mem_write(a_wr), .data_out(a_dout), .mem_ready(a_ready),
    .mem_err(a_err), .busy(a_busy)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .physical_addr(b_addr), .data_in(b_din), .wstrb(b_strb),
    .mem_read(b_rd), .mem_write(b_wr), .data_out(b_dout), .mem_ready(b_ready),
    .mem_err(b_err), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic a_idle();
    a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'd0; a_din = 32'd0; a_strb = 4'd0;
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance, checked cycle by cycle against the model
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] strb, input string tag);
    logic        exp_err;
    logic [31:0] exp_dout;
    logic [31:0] w;
    int          idx;
    exp_err  = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4)) || (rd && wr);
    idx      = int'(addr / 4) % DEPTH;
    exp_dout = (exp_err || wr) ? 32'd0 : model[idx];
    a_rd = rd; a_wr = wr; a_addr = addr; a_din = wd; a_strb = strb;
    for (int k = 1; k <= WC + 1; k++) begin
      @(posedge clk); #1;
      check_eq({tag, ".busy"}, 32'(a_busy), 32'd1);
      check_eq({tag, ".ready"}, 32'(a_ready), (k == WC + 1) ? 32'd1 : 32'd0);
    end
    check_eq({tag, ".err"}, 32'(a_err), 32'(exp_err));
    check_eq({tag, ".dout"}, a_dout, exp_dout);
    last_dout = a_dout;
    last_err  = a_err;
    a_idle();
    @(posedge clk); #1;
    check_eq({tag, ".busy_after"}, 32'(a_busy), 32'd0);
    check_eq({tag, ".ready_after"}, 32'(a_ready), 32'd0);
    check_eq({tag, ".dout_held"}, a_dout, exp_dout);
    if (!exp_err && wr) begin
      w = model[idx];
      for (int i = 0; i < 4; i++)
        if (strb[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[idx] = w;
    end
  endtask

  initial begin
    int          pulses;
    logic [31:0] addr;
    int          t, sel, wi;

    reset = 1'b0;
    a_idle();
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_din = 32'd0; b_strb = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.a_ready", 32'(a_ready), 32'd0);
    check_eq("rst.a_err", 32'(a_err), 32'd0);
    check_eq("rst.a_dout", a_dout, 32'd0);
    check_eq("rst.a_busy", 32'(a_busy), 32'd0);
    check_eq("rst.b_busy", 32'(b_busy), 32'd0);
    check_eq("rst.b_ready", 32'(b_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill the word pool used by random traffic so every read has a known value
    for (int i = 0; i <= 16; i++) begin
      wi = (i == 16) ? DEPTH - 1 : i;
      txn(1'b0, 1'b1, 32'(wi * 4), $urandom, 4'hF, "init");
    end

    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
    txn(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, "rd10");
    check_eq("rd10.lit", last_dout, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, "wr40a");
    txn(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'h5, "wr40b");
    txn(1'b1, 1'b0, 32'h40, 32'd0, 4'h0, "rd40");
    check_eq("rd40.lit", last_dout, 32'h11BB33DD);

    txn(1'b0, 1'b1, 32'h0, 32'h55, 4'hF, "wr0");
    txn(1'b0, 1'b1, 32'h1000, 32'h99, 4'hF, "wr1000");
    check_eq("wr1000.lit_err", 32'(last_err), 32'd1);
    txn(1'b1, 1'b0, 32'h0, 32'd0, 4'h0, "rd0");
    check_eq("rd0.lit", last_dout, 32'h55);
    txn(1'b1, 1'b0, 32'hFFC, 32'd0, 4'h0, "rdFFC");
    check_eq("rdFFC.lit_err", 32'(last_err), 32'd0);

    txn(1'b1, 1'b0, 32'h12, 32'd0, 4'h0, "rd12");
    check_eq("rd12.lit_err", 32'(last_err), 32'd1);
    txn(1'b0, 1'b1, 32'h20, 32'h1234, 4'hF, "wr20");
    txn(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, "rw20");
    check_eq("rw20.lit_err", 32'(last_err), 32'd1);
    txn(1'b1, 1'b0, 32'h20, 32'd0, 4'h0, "rd20a");
    check_eq("rd20a.lit", last_dout, 32'h1234);
    txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, "wr20_nostrb");
    check_eq("wr20_nostrb.lit_err", 32'(last_err), 32'd0);

    // Reset during WAIT aborts a write
    a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h20; a_din = 32'hFFFF; a_strb = 4'hF;
    @(posedge clk); #1;
    check_eq("abort.busy_wait", 32'(a_busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    a_idle();
    check_eq("abort.ready", 32'(a_ready), 32'd0);
    check_eq("abort.err", 32'(a_err), 32'd0);
    check_eq("abort.dout", a_dout, 32'd0);
    check_eq("abort.busy", 32'(a_busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (a_ready) pulses++;
    end
    check_eq("abort.no_pulse", 32'(pulses), 32'd0);
    txn(1'b1, 1'b0, 32'h20, 32'd0, 4'h0, "rd20b");
    check_eq("rd20b.lit", last_dout, 32'h1234);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      wi   = $urandom_range(0, 16);
      addr = (wi == 16) ? 32'((DEPTH - 1) * 4) : 32'(wi * 4);
      sel  = $urandom_range(0, 9);
      if (sel == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (sel == 1) addr = addr | (32'd1 << $urandom_range(12, 31));
      t = $urandom_range(0, 9);
      txn(t >= 5, t < 5 || t == 9, addr, $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    // Zero-wait instance: preload three words, then back-to-back reads
    for (int i = 0; i < 3; i++) begin
      b_words[i] = $urandom;
      b_wr = 1'b1; b_addr = 32'(i * 4); b_din = b_words[i]; b_strb = 4'hF;
      @(posedge clk); #1;
      check_eq("w0.wr_ready", 32'(b_ready), 32'd1);
      b_wr = 1'b0;
      @(posedge clk); #1;
      check_eq("w0.wr_idle", 32'(b_busy), 32'd0);
    end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      check_eq("w0.ready", 32'(b_ready), (c % 2 == 1 && c <= 5) ? 32'd1 : 32'd0);
      check_eq("w0.busy", 32'(b_busy), (c % 2 == 1 && c <= 5) ? 32'd1 : 32'd0);
      if (b_ready) begin
        pulses++;
        check_eq("w0.dout", b_dout, b_words[(c - 1) / 2]);
        check_eq("w0.err", 32'(b_err), 32'd0);
      end
      if (c % 2 == 0 && c <= 4) begin
        b_rd = 1'b1; b_addr = 32'((c / 2) * 4);
      end else begin
        b_rd = 1'b0; b_addr = 32'd0;
      end
    end
    check_eq("w0.pulses", 32'(pulses), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory request interface. It accepts one read or write request at a time on the address/data/read/write handshake driven by the MMU. It services the request against an internal word-organised SRAM array after a programmable number of wait states, then returns read data, a one-cycle `mem_ready` pulse and an error flag. It sits below the MMU and cache as the terminating memory model/controller for simulation and FPGA builds.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 16..65536. `ADDR_W = $clog2(DEPTH_WORDS)`.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset), sampled on the `clk` rising edge.
- `physical_addr`  in  32  byte address of the request.
- `data_in`  in  32  write data.
- `wstrb`  in  4  byte-lane write enables; bit i enables `data_in[8i+7:8i]`.
- `mem_read`  in  1  read request.
- `mem_write`  in  1  write request.
- `data_out`  out  32  read data; valid while `mem_ready`=1, held until the next response.
- `mem_ready`  out  1  one-cycle response pulse.
- `mem_err`  out  1  error status of the current response; valid with `mem_ready`, held until the next response.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - A request is sampled when `mem_read | mem_write` = 1.
  - On a request, latch `physical_addr`, `data_in`, `wstrb` and the request type.
  - Next state is WAIT with counter = `WAIT_CYCLES`-1 if `WAIT_CYCLES` > 0; otherwise RESP.
- **WAIT**: decrement the counter; move to RESP after the cycle in which the counter is 0. Inputs are ignored in this state; latched values are used.
- **Commit on entry to RESP** (the same edge that sets `mem_ready`)
  - Read: `data_out` <= array[word index].
  - Write: update only the lanes enabled by `wstrb`. `data_out` <= 0.
- **RESP**: `mem_ready`=1 for exactly this cycle; next state is IDLE.
- Word index is `physical_addr[ADDR_W+1:2]`.
- **Error** (`mem_err`=1, array untouched, `data_out`=0) on any of:
  - `physical_addr[1:0]` != 0;
  - any bit of `physical_addr[31:ADDR_W+2]` = 1 (out of range; no aliasing);
  - `mem_read` and `mem_write` both 1 when sampled.
- A write with `wstrb`=0 completes normally with no lanes updated and `mem_err`=0.
- Requester contract: hold the request and its inputs stable until the cycle in which `mem_ready`=1.
  - The requester must deassert the request, or present a new one, from the following cycle onward.
  - IDLE never sees a stale request, so no duplicate response can occur.
- Array contents are not cleared by reset and are X until written.

## Timing
- Reset (`reset`=0 at an edge) sets state to IDLE and counter to 0. Output reset values:
  - `mem_ready`=0
  - `mem_err`=0
  - `data_out`=0
  - `busy`=0
- Reset in WAIT or RESP aborts the request: no `mem_ready` pulse and no array write. The write commits only at the RESP-entry edge, so a reset asserted at that edge wins.
- Latency: request first present in cycle T (state IDLE) gives `mem_ready`=1 in cycle T+1+`WAIT_CYCLES`.
- `busy`=1 in cycles T+1 .. T+1+`WAIT_CYCLES`.
- Throughput: one request every `WAIT_CYCLES`+2 cycles. A new request may be present in cycle T+2+`WAIT_CYCLES` (IDLE).
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- `WAIT_CYCLES`=2, write 0xDEADBEEF to 0x10 with `wstrb`=0xF, request in cycle T -> `mem_ready`=1 only in T+3, `mem_err`=0. Then read 0x10 -> `data_out`=0xDEADBEEF, `mem_err`=0.
- Write 0x11223344 to 0x40 with `wstrb`=0xF, then 0xAABBCCDD to 0x40 with `wstrb`=0x5 -> read 0x40 returns 0x11BB33DD.
- `DEPTH_WORDS`=1024: write 0x55 to 0x0, then write 0x99 to 0x1000 -> `mem_err`=1. Read 0x0 -> 0x55, `mem_err`=0. Read 0xFFC -> no error.
- Read 0x12 -> `mem_err`=1, `data_out`=0. Read and write both asserted at 0x20 -> `mem_err`=1 and the array word at 0x20 is unchanged.
- Write 0x1234 to 0x20. Then write 0xFFFF to 0x20 and assert `reset`=0 for one cycle during WAIT -> no `mem_ready` pulse, all outputs at reset values. A subsequent read of 0x20 -> 0x1234.
- `WAIT_CYCLES`=0, back-to-back reads of 0x0, 0x4, 0x8, each presented the cycle after the previous `mem_ready` -> `mem_ready` every 2nd cycle with correct data, exactly three pulses, `busy` toggling 1/0.
